rps_match_judge: RTL and testbench

//  Upstream stage of scoreupdate. Accepts one rock/paper/scissors move per player through a

---
 rtl/rps_match_judge_pkg.sv | 36 +++
 rtl/rps_match_judge_if.sv | 26 ++
 rtl/rps_match_judge_compare.sv | 35 +++
 rtl/rps_match_judge.sv | 145 ++++++++++++++
 tb/tb_rps_match_judge.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rps_match_judge_pkg.sv
// -----------------------------------------------------------------------------
// rps_match_judge_pkg
//   Shared types for the rock/paper/scissors round judge: move encoding,
//   result codes, FSM states and the "who beats whom" rule.
// -----------------------------------------------------------------------------
package rps_match_judge_pkg;

    typedef enum logic [1:0] {
        MOVE_NONE     = 2'b00,
        MOVE_ROCK     = 2'b01,
        MOVE_PAPER    = 2'b10,
        MOVE_SCISSORS = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        RES_IDLE = 2'b00,
        RES_DRAW = 2'b01,
        RES_P1   = 2'b10,
        RES_P2   = 2'b11
    } result_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_JUDGE  = 2'b10,
        S_REPORT = 2'b11
    } state_e;

    // True when move a defeats move b (both must be real moves).
    function automatic logic beats(input move_e a, input move_e b);
        return (a == MOVE_ROCK     && b == MOVE_SCISSORS) ||
               (a == MOVE_SCISSORS && b == MOVE_PAPER)    ||
               (a == MOVE_PAPER    && b == MOVE_ROCK);
    endfunction

endpackage

// File: rtl/rps_match_judge_if.sv
// -----------------------------------------------------------------------------
// rps_match_judge_if
//   Player-side handshake bundle: one move/valid/ready channel per player.
//   master : the players (drive move + valid, observe ready)
//   slave  : the judge   (observe move + valid, drive ready)
// -----------------------------------------------------------------------------
interface rps_match_judge_if;

    logic [1:0] p1_move;
    logic       p1_valid;
    logic       p1_ready;
    logic [1:0] p2_move;
    logic       p2_valid;
    logic       p2_ready;

    modport master (
        output p1_move, p1_valid, p2_move, p2_valid,
        input  p1_ready, p2_ready
    );

    modport slave (
        input  p1_move, p1_valid, p2_move, p2_valid,
        output p1_ready, p2_ready
    );

endinterface

// File: rtl/rps_match_judge_compare.sv
// -----------------------------------------------------------------------------
// rps_match_judge_compare
//   Purely combinational round decision.
//   m1_i, m2_i           : moves held in the player slots
//   forfeit1_i/forfeit2_i: player never submitted a move before timeout
//   result_o             : draw / P1 wins / P2 wins
// -----------------------------------------------------------------------------
module rps_match_judge_compare
    import rps_match_judge_pkg::*;
(
    input  move_e   m1_i,
    input  move_e   m2_i,
    input  logic    forfeit1_i,
    input  logic    forfeit2_i,
    output result_e result_o
);

    always_comb begin
        if (forfeit1_i && forfeit2_i) begin
            // Unreachable: a round only starts once someone has moved.
            result_o = RES_DRAW;
        end else if (forfeit1_i) begin
            result_o = RES_P2;
        end else if (forfeit2_i) begin
            result_o = RES_P1;
        end else if (m1_i == m2_i) begin
            result_o = RES_DRAW;
        end else if (beats(m1_i, m2_i)) begin
            result_o = RES_P1;
        end else begin
            result_o = RES_P2;
        end
    end

endmodule

// File: rtl/rps_match_judge.sv
// -----------------------------------------------------------------------------
// rps_match_judge
//   Collects one move per player, waits up to TIMEOUT_CYCLES for a missing
//   player, then emits a single-cycle registered result code.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   players      : per-player move/valid/ready handshake (slave side)
//   game_over    : downstream hold-off; blocks new moves while high
//   matchresult  : 00 idle, 01 draw, 10 P1 wins, 11 P2 wins (1-cycle pulse)
//   last_p1/p2   : moves of the last judged round (00 = forfeit)
//   busy         : high while a round is in progress
// -----------------------------------------------------------------------------
module rps_match_judge
    import rps_match_judge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMER_W        = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    rps_match_judge_if.slave     players,
    input  logic                 game_over,
    output logic [1:0]           matchresult,
    output logic [1:0]           last_p1,
    output logic [1:0]           last_p2,
    output logic                 busy
);

    state_e               state_q, state_d;
    move_e                slot1_q, slot1_d;
    move_e                slot2_q, slot2_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    result_e              result_q, result_d;
    move_e                last1_q, last1_d;
    move_e                last2_q, last2_d;
    logic                 busy_q, busy_d;

    logic                 ready1, ready2;
    logic                 acc1, acc2;
    logic                 timeout_hit;
    result_e              cmp_result;

    // An empty slot holds MOVE_NONE, so the slot itself doubles as the
    // full flag and as the forfeit marker at judge time.
    always_comb begin
        ready1      = (state_q == S_IDLE || state_q == S_WAIT) &&
                      (slot1_q == MOVE_NONE) && !game_over;
        ready2      = (state_q == S_IDLE || state_q == S_WAIT) &&
                      (slot2_q == MOVE_NONE) && !game_over;
        acc1        = players.p1_valid && ready1 && (players.p1_move != 2'b00);
        acc2        = players.p2_valid && ready2 && (players.p2_move != 2'b00);
        timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    end

    assign players.p1_ready = ready1;
    assign players.p2_ready = ready2;

    rps_match_judge_compare u_compare (
        .m1_i       (slot1_q),
        .m2_i       (slot2_q),
        .forfeit1_i (slot1_q == MOVE_NONE),
        .forfeit2_i (slot2_q == MOVE_NONE),
        .result_o   (cmp_result)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d  = state_q;
        slot1_d  = slot1_q;
        slot2_d  = slot2_q;
        timer_d  = timer_q;
        result_d = result_q;
        last1_d  = last1_q;
        last2_d  = last2_q;

        if (acc1) slot1_d = move_e'(players.p1_move);
        if (acc2) slot2_d = move_e'(players.p2_move);

        case (state_q)
            S_IDLE: begin
                if (acc1 && acc2) begin
                    state_d = S_JUDGE;
                end else if (acc1 || acc2) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                // Only the empty slot can accept here, and an accept on the
                // timeout edge takes priority over the forfeit.
                if (acc1 || acc2 || timeout_hit) begin
                    state_d = S_JUDGE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_JUDGE: begin
                result_d = cmp_result;
                last1_d  = slot1_q;
                last2_d  = slot2_q;
                state_d  = S_REPORT;
            end
            S_REPORT: begin
                result_d = RES_IDLE;
                slot1_d  = MOVE_NONE;
                slot2_d  = MOVE_NONE;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            slot1_q  <= MOVE_NONE;
            slot2_q  <= MOVE_NONE;
            timer_q  <= '0;
            result_q <= RES_IDLE;
            last1_q  <= MOVE_NONE;
            last2_q  <= MOVE_NONE;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot1_q  <= slot1_d;
            slot2_q  <= slot2_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            last1_q  <= last1_d;
            last2_q  <= last2_d;
            busy_q   <= busy_d;
        end
    end

    // Outputs come straight from flops: downstream gates clocks off them.
    assign matchresult = result_q;
    assign last_p1     = last1_q;
    assign last_p2     = last2_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_rps_match_judge.sv
// -----------------------------------------------------------------------------
// tb_rps_match_judge
//   Self-checking bench: stimulus pushes expected round outcomes into a
//   scoreboard queue; a negedge monitor pops one entry per result pulse.
// -----------------------------------------------------------------------------
module tb_rps_match_judge;

    localparam int TO = 8;
    localparam int TW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_over;
    logic [1:0] matchresult;
    logic [1:0] last_p1;
    logic [1:0] last_p2;
    logic       busy;

    rps_match_judge_if players ();

    rps_match_judge #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .players     (players.slave),
        .game_over   (game_over),
        .matchresult (matchresult),
        .last_p1     (last_p1),
        .last_p2     (last_p2),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] res;
        logic [1:0] l1;
        logic [1:0] l2;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_pulse = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: 0 = no move (forfeit). With rock=1, paper=2,
    // scissors=3 the first player wins when (a - b) mod 3 == 1.
    function automatic logic [1:0] ref_judge(input int a, input int b);
        if (a == 0)                 return 2'b11;
        if (b == 0)                 return 2'b10;
        if (a == b)                 return 2'b01;
        if ((a - b + 3) % 3 == 1)   return 2'b10;
        return 2'b11;
    endfunction

    task automatic push_round(input int a, input int b);
        exp_t e;
        e.res = ref_judge(a, b);
        e.l1  = 2'(a);
        e.l2  = 2'(b);
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (matchresult != 2'b00) begin
            check("pulse_one_cycle", int'(prev_pulse), 0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got matchresult %0d expected none at %0t",
                         matchresult, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result",  int'(matchresult), int'(e.res));
                check("sb_last_p1", int'(last_p1),     int'(e.l1));
                check("sb_last_p2", int'(last_p2),     int'(e.l2));
            end
        end
        prev_pulse <= (matchresult != 2'b00);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int who, input logic v, input logic [1:0] m);
        if (who == 1) begin
            players.p1_valid = v;
            players.p1_move  = m;
        end else begin
            players.p2_valid = v;
            players.p2_move  = m;
        end
    endtask

    task automatic clear_inputs();
        drive(1, 1'b0, 2'b00);
        drive(2, 1'b0, 2'b00);
    endtask

    task automatic probe(input string tag, input logic r1, input logic r2, input logic b);
        @(negedge clk);
        check({tag, "_p1_ready"}, int'(players.p1_ready), int'(r1));
        check({tag, "_p2_ready"}, int'(players.p2_ready), int'(r2));
        check({tag, "_busy"},     int'(busy),             int'(b));
    endtask

    // Both moves on the same edge; checks the k+1..k+2 result window.
    task automatic run_both(input int a, input int b);
        drive(1, 1'b1, 2'(a));
        drive(2, 1'b1, 2'(b));
        step();
        clear_inputs();
        push_round(a, b);
        @(negedge clk);
        check("both_judge_mr", int'(matchresult), 0);
        step();
        @(negedge clk);
        check("both_report_mr", int'(matchresult), int'(ref_judge(a, b)));
        check("both_report_l1", int'(last_p1), a);
        check("both_report_l2", int'(last_p2), b);
        step();
        probe("both_idle", 1'b1, 1'b1, 1'b0);
        check("both_idle_mr", int'(matchresult), 0);
    endtask

    // First player f moves, the other follows d edges later (1..TO).
    task automatic run_split(input int f, input int a, input int b, input int d);
        int o = (f == 1) ? 2 : 1;
        drive(f, 1'b1, 2'((f == 1) ? a : b));
        step();
        for (int i = 1; i < d; i++) begin
            drive(f, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
            drive(o, 1'($urandom_range(0, 1)), 2'b00);
            probe("split_wait", (f == 1) ? 1'b0 : 1'b1, (f == 1) ? 1'b1 : 1'b0, 1'b1);
            step();
        end
        drive(o, 1'b1, 2'((o == 1) ? a : b));
        drive(f, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
        step();
        clear_inputs();
        push_round(a, b);
        step();
        step();
        probe("split_idle", 1'b1, 1'b1, 1'b0);
    endtask

    // Only player f ever moves; the other forfeits after TO WAIT cycles.
    task automatic run_timeout(input int f, input int m);
        int o = (f == 1) ? 2 : 1;
        drive(f, 1'b1, 2'(m));
        step();
        for (int i = 1; i <= TO; i++) begin
            drive(f, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)));
            drive(o, 1'($urandom_range(0, 1)), 2'b00);
            probe("to_wait", (f == 1) ? 1'b0 : 1'b1, (f == 1) ? 1'b1 : 1'b0, 1'b1);
            step();
        end
        clear_inputs();
        probe("to_judge", 1'b0, 1'b0, 1'b1);
        if (f == 1) push_round(m, 0);
        else        push_round(0, m);
        step();
        step();
        probe("to_idle", 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        game_over = 1'b0;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        probe("reset", 1'b1, 1'b1, 1'b0);
        check("reset_mr", int'(matchresult), 0);
        check("reset_l1", int'(last_p1), 0);
        check("reset_l2", int'(last_p2), 0);

        // Rock beats scissors, both on one edge.
        run_both(1, 3);
        // Paper vs paper, P2 three cycles later.
        run_split(1, 2, 2, 3);
        // P2 rock alone: P1 forfeits on timeout.
        run_timeout(2, 1);
        // Second move on the exact timeout edge still counts.
        run_split(2, 3, 2, TO);

        // Move 00 with valid is not an accept.
        drive(1, 1'b1, 2'b00);
        step();
        clear_inputs();
        probe("zero_move", 1'b1, 1'b1, 1'b0);
        step();

        // Reset while waiting: no pulse, everything back to idle.
        drive(2, 1'b1, 2'b01);
        step();
        clear_inputs();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        probe("rst_wait", 1'b1, 1'b1, 1'b0);
        check("rst_wait_mr", int'(matchresult), 0);
        check("rst_wait_l1", int'(last_p1), 0);
        check("rst_wait_l2", int'(last_p2), 0);
        repeat (TO + 4) step();

        // game_over during WAIT: round finishes by forfeit, then inputs ignored.
        drive(1, 1'b1, 2'b01);
        step();
        game_over = 1'b1;
        clear_inputs();
        for (int i = 1; i <= TO; i++) begin
            drive(2, 1'b1, 2'b10);
            probe("go_wait", 1'b0, 1'b0, 1'b1);
            step();
        end
        clear_inputs();
        push_round(1, 0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 2'b11);
            drive(2, 1'b1, 2'b01);
            probe("go_blocked", 1'b0, 1'b0, 1'b0);
            step();
        end
        clear_inputs();
        game_over = 1'b0;
        step();
        probe("go_released", 1'b1, 1'b1, 1'b0);

        // Randomised rounds.
        for (int r = 0; r < 40; r++) begin
            int mode = $urandom_range(0, 2);
            int a    = $urandom_range(1, 3);
            int b    = $urandom_range(1, 3);
            int f    = $urandom_range(1, 2);
            case (mode)
                0:       run_both(a, b);
                1:       run_split(f, a, b, $urandom_range(1, TO));
                default: run_timeout(f, a);
            endcase
        end

        repeat (3) step();
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
